// File: rtl/divider_32bit_if.sv
// rtl/divider_32bit_if.sv - start/operand/result bundle for divider_32bit
//
// Purpose: groups the divider's command and result signals. The requester
// drives the start pulse and operands; the divider returns the results and
// the ready strobe.
// Ports (signals):
//   ctrl_DIV   start pulse (requester -> divider)
//   dataA      32-bit two's-complement dividend
//   dataB      32-bit two's-complement divisor
//   Quotient   32-bit signed quotient, truncated toward zero
//   Remainder  32-bit signed remainder, sign of the dividend
//   Exception  divide-by-zero or 0x80000000 / -1
//   ResultRDY  one-cycle strobe marking valid results
interface divider_32bit_if;
  logic        ctrl_DIV;
  logic [31:0] dataA;
  logic [31:0] dataB;
  logic [31:0] Quotient;
  logic [31:0] Remainder;
  logic        Exception;
  logic        ResultRDY;

  modport master (
    output ctrl_DIV, dataA, dataB,
    input  Quotient, Remainder, Exception, ResultRDY
  );

  modport slave (
    input  ctrl_DIV, dataA, dataB,
    output Quotient, Remainder, Exception, ResultRDY
  );
endinterface

// File: rtl/divider_32bit.sv
// rtl/divider_32bit.sv - multi-cycle signed 32-bit restoring divider
//
// Purpose: signed 32/32 division, one quotient bit per cycle via a 33-bit
// trial subtraction. Start edge + 32 iterations + 1 result edge; ResultRDY
// pulses for one cycle after the result edge.
// Ports:
//   clock  sole clock, rising edge
//   reset  synchronous, active-high
//   bus    divider_32bit_if.slave (ctrl_DIV, dataA, dataB in;
//          Quotient, Remainder, Exception, ResultRDY out, all registered)
module divider_32bit (
  input  logic            clock,
  input  logic            reset,
  divider_32bit_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state, state_nxt;
  logic [5:0]  cnt;
  logic [31:0] d_reg;       // dividend bits shift out, quotient bits shift in
  logic [31:0] b_reg;       // |divisor|
  // The partial remainder always stays below |divisor| <= 2^31, so it fits
  // in 32 bits; the 33rd bit only exists in the shifted/trial values.
  logic [31:0] p_reg;
  logic        sign_a, sign_b;
  logic        exc_zero, exc_ovf;

  logic [31:0] quotient_q, remainder_q;
  logic        exception_q, rdy_q;

  logic        start, last_iter;
  logic [31:0] abs_a, abs_b;
  logic [32:0] p_shift, trial;
  logic [31:0] q_signed, r_signed;

  assign start     = bus.ctrl_DIV;
  assign last_iter = (state == RUN) && (cnt == 6'd32);

  // |0x80000000| wraps back to 0x80000000, which is correct read unsigned.
  assign abs_a = bus.dataA[31] ? (~bus.dataA + 32'd1) : bus.dataA;
  assign abs_b = bus.dataB[31] ? (~bus.dataB + 32'd1) : bus.dataB;

  assign p_shift = {p_reg, d_reg[31]};
  assign trial   = p_shift - {1'b0, b_reg};

  // After 32 iterations d_reg holds the quotient magnitude, p_reg the remainder.
  assign q_signed = (sign_a ^ sign_b) ? (~d_reg + 32'd1) : d_reg;
  assign r_signed = sign_a ? (~p_reg + 32'd1) : p_reg;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = RUN;
    end else begin
      case (state)
        IDLE:    state_nxt = IDLE;
        RUN:     state_nxt = last_iter ? DONE : RUN;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt         <= 6'd0;
      d_reg       <= 32'd0;
      b_reg       <= 32'd0;
      p_reg       <= 32'd0;
      sign_a      <= 1'b0;
      sign_b      <= 1'b0;
      exc_zero    <= 1'b0;
      exc_ovf     <= 1'b0;
      quotient_q  <= 32'd0;
      remainder_q <= 32'd0;
      exception_q <= 1'b0;
      rdy_q       <= 1'b0;
    end else begin
      rdy_q <= 1'b0;
      if (start) begin
        // A start in RUN or DONE simply overwrites the operation in flight.
        d_reg    <= abs_a;
        b_reg    <= abs_b;
        p_reg    <= 32'd0;
        cnt      <= 6'd0;
        sign_a   <= bus.dataA[31];
        sign_b   <= bus.dataB[31];
        exc_zero <= (bus.dataB == 32'd0);
        exc_ovf  <= (bus.dataA == 32'h8000_0000) && (bus.dataB == 32'hFFFF_FFFF);
      end else if (state == RUN) begin
        if (last_iter) begin
          // Exception cases still iterate so latency is uniform; results are
          // overridden here.
          if (exc_zero) begin
            quotient_q  <= 32'd0;
            remainder_q <= 32'd0;
          end else if (exc_ovf) begin
            quotient_q  <= 32'h8000_0000;
            remainder_q <= 32'd0;
          end else begin
            quotient_q  <= q_signed;
            remainder_q <= r_signed;
          end
          exception_q <= exc_zero | exc_ovf;
          rdy_q       <= 1'b1;
        end else begin
          cnt   <= cnt + 6'd1;
          p_reg <= trial[32] ? p_shift[31:0] : trial[31:0];
          d_reg <= {d_reg[30:0], ~trial[32]};
        end
      end
    end
  end

  assign bus.Quotient  = quotient_q;
  assign bus.Remainder = remainder_q;
  assign bus.Exception = exception_q;
  assign bus.ResultRDY = rdy_q;

endmodule

// File: tb/tb_divider_32bit.sv
// tb/tb_divider_32bit.sv - self-checking scoreboard bench for divider_32bit
module tb_divider_32bit;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        e;
  } exp_t;

  logic clock;
  logic reset;
  int   errors;
  int   checks;
  exp_t sb[$];

  divider_32bit_if bus();

  divider_32bit dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   sa;
    int   sbv;
    if (b == 32'd0) begin
      e.q = 32'd0; e.r = 32'd0; e.e = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.q = 32'h8000_0000; e.r = 32'd0; e.e = 1'b1;
    end else begin
      sa  = a;
      sbv = b;
      e.q = sa / sbv;
      e.r = sa % sbv;
      e.e = 1'b0;
    end
    return e;
  endfunction

  // Called at a negedge; returns at the negedge right after the start edge.
  task automatic drive_start(input logic [31:0] a, input logic [31:0] b);
    bus.dataA    = a;
    bus.dataB    = b;
    bus.ctrl_DIV = 1'b1;
    @(negedge clock);
    bus.ctrl_DIV = 1'b0;
    bus.dataA    = $urandom;
    bus.dataB    = $urandom;
  endtask

  // Counts cycles after the start edge until ResultRDY, bounded.
  task automatic wait_rdy(output int n);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!bus.ResultRDY && n < 100);
  endtask

  task automatic test_reset;
    reset        = 1'b1;
    bus.ctrl_DIV = 1'b1;
    bus.dataA    = 32'd100;
    bus.dataB    = 32'd7;
    @(negedge clock);
    bus.ctrl_DIV = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    checks++; if (bus.Quotient  !== 32'd0) begin errors++; $display("FAIL reset_q: got %h want 0", bus.Quotient); end
    checks++; if (bus.Remainder !== 32'd0) begin errors++; $display("FAIL reset_r: got %h want 0", bus.Remainder); end
    checks++; if (bus.Exception !== 1'b0)  begin errors++; $display("FAIL reset_e: got %b want 0", bus.Exception); end
    checks++; if (bus.ResultRDY !== 1'b0)  begin errors++; $display("FAIL reset_rdy: got %b want 0", bus.ResultRDY); end
    begin
      int strobes;
      strobes = 0;
      repeat (40) begin
        @(negedge clock);
        if (bus.ResultRDY === 1'b1) strobes++;
      end
      checks++; if (strobes != 0) begin errors++; $display("FAIL reset_with_start_strobe: got %0d strobes want 0", strobes); end
    end
  endtask

  task automatic test_basic;
    int   n;
    exp_t e;
    drive_start(32'd100, 32'd7);
    sb.push_back('{q: 32'd14, r: 32'd2, e: 1'b0});
    wait_rdy(n);
    e = sb.pop_front();
    checks++; if (n != 33) begin errors++; $display("FAIL basic_latency: got %0d want 33", n); end
    checks++; if (bus.Quotient  !== e.q) begin errors++; $display("FAIL basic_q: got %h want %h", bus.Quotient, e.q); end
    checks++; if (bus.Remainder !== e.r) begin errors++; $display("FAIL basic_r: got %h want %h", bus.Remainder, e.r); end
    checks++; if (bus.Exception !== e.e) begin errors++; $display("FAIL basic_e: got %b want %b", bus.Exception, e.e); end
    @(negedge clock);
    checks++; if (bus.ResultRDY !== 1'b0) begin errors++; $display("FAIL basic_strobe_width: got %b want 0", bus.ResultRDY); end
    repeat (5) @(negedge clock);
    checks++; if (bus.Quotient !== e.q || bus.Remainder !== e.r) begin
      errors++; $display("FAIL basic_hold: got %h/%h want %h/%h", bus.Quotient, bus.Remainder, e.q, e.r);
    end
  endtask

  task automatic test_table(input string name, input int idx0);
    logic [31:0] ta[8];
    logic [31:0] tb_[8];
    logic [31:0] tq[8];
    logic [31:0] tr[8];
    logic        te[8];
    int          n;
    exp_t        e;
    // signs
    ta[0] = -32'sd100;     tb_[0] = 32'd7;          tq[0] = 32'hFFFF_FFF2; tr[0] = 32'hFFFF_FFFE; te[0] = 1'b0;
    ta[1] = 32'd100;       tb_[1] = -32'sd7;        tq[1] = 32'hFFFF_FFF2; tr[1] = 32'd2;        te[1] = 1'b0;
    ta[2] = -32'sd100;     tb_[2] = -32'sd7;        tq[2] = 32'd14;        tr[2] = 32'hFFFF_FFFE; te[2] = 1'b0;
    ta[3] = 32'd200;       tb_[3] = 32'd9;          tq[3] = 32'd22;        tr[3] = 32'd2;        te[3] = 1'b0;
    // exceptions and boundaries
    ta[4] = 32'd5;         tb_[4] = 32'd0;          tq[4] = 32'd0;         tr[4] = 32'd0;        te[4] = 1'b1;
    ta[5] = 32'h8000_0000; tb_[5] = 32'hFFFF_FFFF;  tq[5] = 32'h8000_0000; tr[5] = 32'd0;        te[5] = 1'b1;
    ta[6] = 32'h8000_0000; tb_[6] = 32'd1;          tq[6] = 32'h8000_0000; tr[6] = 32'd0;        te[6] = 1'b0;
    ta[7] = 32'h7FFF_FFFF; tb_[7] = 32'h7FFF_FFFF;  tq[7] = 32'd1;         tr[7] = 32'd0;        te[7] = 1'b0;
    for (int i = idx0; i < idx0 + 4; i++) begin
      drive_start(ta[i], tb_[i]);
      sb.push_back('{q: tq[i], r: tr[i], e: te[i]});
      wait_rdy(n);
      e = sb.pop_front();
      checks++; if (n != 33) begin errors++; $display("FAIL %s_latency[%0d]: got %0d want 33", name, i, n); end
      checks++; if (bus.Quotient  !== e.q) begin errors++; $display("FAIL %s_q[%0d]: got %h want %h", name, i, bus.Quotient, e.q); end
      checks++; if (bus.Remainder !== e.r) begin errors++; $display("FAIL %s_r[%0d]: got %h want %h", name, i, bus.Remainder, e.r); end
      checks++; if (bus.Exception !== e.e) begin errors++; $display("FAIL %s_e[%0d]: got %b want %b", name, i, bus.Exception, e.e); end
      @(negedge clock);
    end
  endtask

  task automatic test_random;
    logic [31:0] a;
    logic [31:0] b;
    int          n;
    exp_t        e;
    for (int i = 0; i < 6; i++) begin
      a = $urandom;
      b = (i < 3) ? 32'($urandom_range(1, 1000)) : $urandom;
      if (i == 1) b = -b;
      if (b == 32'd0) b = 32'd3;
      drive_start(a, b);
      sb.push_back(model(a, b));
      wait_rdy(n);
      e = sb.pop_front();
      checks++; if (n != 33) begin errors++; $display("FAIL random_latency[%0d]: got %0d want 33", i, n); end
      checks++; if (bus.Quotient !== e.q || bus.Remainder !== e.r || bus.Exception !== e.e) begin
        errors++;
        $display("FAIL random_result[%0d] %h/%h: got %h,%h,%b want %h,%h,%b",
                 i, a, b, bus.Quotient, bus.Remainder, bus.Exception, e.q, e.r, e.e);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_restart;
    int   n;
    exp_t e;
    drive_start(32'd1000, 32'd3);
    repeat (9) @(negedge clock);
    drive_start(32'd50, 32'd5);
    sb.push_back('{q: 32'd10, r: 32'd0, e: 1'b0});
    wait_rdy(n);
    e = sb.pop_front();
    checks++; if (n != 33) begin errors++; $display("FAIL restart_latency: got %0d want 33", n); end
    checks++; if (bus.Quotient  !== e.q) begin errors++; $display("FAIL restart_q: got %h want %h", bus.Quotient, e.q); end
    checks++; if (bus.Remainder !== e.r) begin errors++; $display("FAIL restart_r: got %h want %h", bus.Remainder, e.r); end
    @(negedge clock);
  endtask

  task automatic test_back_to_back;
    int   n;
    exp_t e;
    drive_start(32'd200, 32'd9);
    sb.push_back('{q: 32'd22, r: 32'd2, e: 1'b0});
    wait_rdy(n);
    e = sb.pop_front();
    checks++; if (n != 33) begin errors++; $display("FAIL b2b_latency0: got %0d want 33", n); end
    checks++; if (bus.Quotient !== e.q || bus.Remainder !== e.r) begin
      errors++; $display("FAIL b2b_result0: got %h/%h want %h/%h", bus.Quotient, bus.Remainder, e.q, e.r);
    end
    // Start sampled on the DONE edge, no idle cycle in between.
    drive_start(32'd77, -32'sd5);
    sb.push_back('{q: 32'hFFFF_FFF1, r: 32'd2, e: 1'b0});
    checks++; if (bus.ResultRDY !== 1'b0) begin errors++; $display("FAIL b2b_strobe_drop: got %b want 0", bus.ResultRDY); end
    wait_rdy(n);
    e = sb.pop_front();
    checks++; if (n != 33) begin errors++; $display("FAIL b2b_latency1: got %0d want 33", n); end
    checks++; if (bus.Quotient !== e.q || bus.Remainder !== e.r || bus.Exception !== e.e) begin
      errors++; $display("FAIL b2b_result1: got %h/%h/%b want %h/%h/%b",
                         bus.Quotient, bus.Remainder, bus.Exception, e.q, e.r, e.e);
    end
    @(negedge clock);
  endtask

  task automatic test_reset_mid_run;
    int   n;
    int   strobes;
    exp_t e;
    drive_start(32'd100, 32'd7);
    repeat (19) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checks++; if (bus.Quotient !== 32'd0 || bus.Remainder !== 32'd0 || bus.Exception !== 1'b0 || bus.ResultRDY !== 1'b0) begin
      errors++; $display("FAIL midreset_outputs: got %h/%h/%b/%b want 0/0/0/0",
                         bus.Quotient, bus.Remainder, bus.Exception, bus.ResultRDY);
    end
    strobes = 0;
    repeat (40) begin
      @(negedge clock);
      if (bus.ResultRDY === 1'b1) strobes++;
    end
    checks++; if (strobes != 0) begin errors++; $display("FAIL midreset_strobe: got %0d strobes want 0", strobes); end
    drive_start(32'd9, 32'd2);
    sb.push_back('{q: 32'd4, r: 32'd1, e: 1'b0});
    wait_rdy(n);
    e = sb.pop_front();
    checks++; if (n != 33) begin errors++; $display("FAIL midreset_latency: got %0d want 33", n); end
    checks++; if (bus.Quotient !== e.q || bus.Remainder !== e.r) begin
      errors++; $display("FAIL midreset_result: got %h/%h want %h/%h", bus.Quotient, bus.Remainder, e.q, e.r);
    end
    @(negedge clock);
  endtask

  initial begin
    errors       = 0;
    checks       = 0;
    reset        = 1'b1;
    bus.ctrl_DIV = 1'b0;
    bus.dataA    = 32'd0;
    bus.dataB    = 32'd0;
    repeat (2) @(negedge clock);
    test_reset();
    test_basic();
    test_table("signs", 0);
    test_table("bound", 4);
    test_random();
    test_restart();
    test_back_to_back();
    test_reset_mid_run();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d left want 0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
